// File: rtl/stopwatch_controller.sv
// Stopwatch control: debounces the keys, generates the count tick and sequences
// start/stop, lap freeze, clear/preset loads and the 59:59 halt for an mm:ss BCD counter chain.
module stopwatch_controller #(
  parameter int unsigned TICK_DIV        = 5000000,
  parameter int unsigned FAST_MULT       = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] PRESET_VALUE    = 16'h5900
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  input  logic [15:0] TIME_BCD,
  output logic        INCREMENT,
  output logic        WRITE_ENABLE,
  output logic [15:0] WRITE_VALUE,
  output logic [15:0] DISP_BCD,
  output logic [2:0]  STATE,
  output logic        RUNNING
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SLOW_W   = (FAST_MULT > 1) ? $clog2(FAST_MULT) : 1;
  localparam int unsigned DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(FAST_MULT - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]       FULL_BCD  = 16'h5959;

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_RUNNING = 3'd1,
    ST_LAP     = 3'd2,
    ST_LOAD    = 3'd3,
    ST_FULL    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NUM_KEYS-1:0] key_s1, key_s2, key_deb;
  logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] deb_done_c, press_c;
  logic                ev_start_c, ev_clear_c, ev_lap_c, fast_c;

  logic [TICK_W-1:0] base_cnt;
  logic [SLOW_W-1:0] slow_cnt;
  logic              base_pulse_c, tick_c, at_full_c, counting_c, presc_clear_c;

  logic [15:0] load_value_c, write_value_d, disp_d;
  logic        increment_d, write_enable_d, running_d;

  // Two-flop synchronizer; released level (1) out of reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
    end
  end

  // A key's debounced level flips once its synced level has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    deb_done_c = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      deb_done_c[i] = (key_s2[i] != key_deb[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      key_deb <= '1;
      for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_s2[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_done_c[i]) begin
          deb_cnt[i] <= '0;
          key_deb[i] <= key_s2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Press = debounced 1->0; same-cycle priority KEY0 > KEY3 > KEY1
  assign press_c    = deb_done_c & key_deb;
  assign ev_start_c = press_c[0];
  assign ev_clear_c = press_c[3] & ~press_c[0];
  assign ev_lap_c   = press_c[1] & ~press_c[0] & ~press_c[3];
  assign fast_c     = ~key_deb[2];

  assign base_pulse_c = (base_cnt == TICK_LAST);
  assign tick_c       = base_pulse_c && (fast_c || (slow_cnt == SLOW_LAST));
  assign at_full_c    = (TIME_BCD == FULL_BCD);
  assign counting_c   = (state_q == ST_RUNNING) || (state_q == ST_LAP);

  // Prescaler free-runs; restarted on start so the first count is a full period
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      base_cnt <= '0;
      slow_cnt <= '0;
    end else if (presc_clear_c) begin
      base_cnt <= '0;
      slow_cnt <= '0;
    end else begin
      base_cnt <= base_pulse_c ? '0 : base_cnt + TICK_W'(1);
      if (base_pulse_c) slow_cnt <= (slow_cnt == SLOW_LAST) ? '0 : slow_cnt + SLOW_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_STOPPED;
      INCREMENT    <= 1'b0;
      WRITE_ENABLE <= 1'b0;
      WRITE_VALUE  <= 16'h0000;
      DISP_BCD     <= 16'h0000;
      RUNNING      <= 1'b0;
    end else begin
      state_q      <= state_d;
      INCREMENT    <= increment_d;
      WRITE_ENABLE <= write_enable_d;
      WRITE_VALUE  <= write_value_d;
      DISP_BCD     <= disp_d;
      RUNNING      <= running_d;
    end
  end

  assign STATE = state_q;

  // Next state; a stop always beats a coincident tick
  always_comb begin
    state_d      = state_q;
    load_value_c = 16'h0000;
    case (state_q)
      ST_STOPPED, ST_FULL: begin
        if (ev_start_c && (state_q == ST_STOPPED)) begin
          state_d = ST_RUNNING;
        end else if (ev_clear_c) begin
          state_d = ST_LOAD;
        end else if (ev_lap_c) begin
          state_d      = ST_LOAD;
          load_value_c = PRESET_VALUE;
        end
      end
      ST_RUNNING, ST_LAP: begin
        if (ev_start_c) begin
          state_d = ST_STOPPED;
        end else if (tick_c && at_full_c) begin
          state_d = ST_FULL;
        end else if (ev_lap_c) begin
          state_d = (state_q == ST_RUNNING) ? ST_LAP : ST_RUNNING;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Output next-values; DISP_BCD freezes only while staying in LAP
  always_comb begin
    increment_d    = 1'b0;
    write_enable_d = 1'b0;
    write_value_d  = WRITE_VALUE;
    disp_d         = TIME_BCD;
    running_d      = 1'b0;
    presc_clear_c  = 1'b0;

    increment_d    = tick_c && counting_c && !at_full_c && !ev_start_c;
    write_enable_d = (state_d == ST_LOAD);
    if (write_enable_d) write_value_d = load_value_c;
    if ((state_q == ST_LAP) && (state_d == ST_LAP)) disp_d = DISP_BCD;
    running_d      = (state_d == ST_RUNNING) || (state_d == ST_LAP);
    presc_clear_c  = (state_q == ST_STOPPED) && (state_d == ST_RUNNING);
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed scenarios then random key activity,
// every cycle compared against a cycle-count based behavioural model.
module tb_stopwatch_controller;

  localparam int unsigned TD = 4;
  localparam int unsigned FM = 3;
  localparam int unsigned DB = 3;
  localparam logic [15:0] PRESET = 16'h5900;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  KEY;
  logic [15:0] TIME_BCD;
  logic        INCREMENT, WRITE_ENABLE, RUNNING;
  logic [15:0] WRITE_VALUE, DISP_BCD;
  logic [2:0]  STATE;

  stopwatch_controller #(
    .TICK_DIV(TD), .FAST_MULT(FM), .DEBOUNCE_CYCLES(DB), .PRESET_VALUE(PRESET)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .KEY(KEY), .TIME_BCD(TIME_BCD),
    .INCREMENT(INCREMENT), .WRITE_ENABLE(WRITE_ENABLE), .WRITE_VALUE(WRITE_VALUE),
    .DISP_BCD(DISP_BCD), .STATE(STATE), .RUNNING(RUNNING)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: modes 0..4 as integers, prescaler as cycles since last restart
  int          m_state;
  int unsigned phase;
  logic        m_inc, m_we, m_run;
  logic [15:0] m_wv, m_disp, m_lap;
  logic [3:0]  m_deb;
  logic [3:0]  raw_hist[$];
  logic [15:0] time_v;
  logic [15:0] prev_time;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    int s, m, sec;
    s = (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]) + 1;
    if (s > 3599) s = 3599;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; phase = 0;
    m_inc = 1'b0; m_we = 1'b0; m_run = 1'b0;
    m_wv = 16'h0; m_disp = 16'h0; m_lap = 16'h0;
    m_deb = 4'hF;
    raw_hist.delete();
    for (int i = 0; i < int'(DB) + 2; i++) raw_hist.push_back(4'hF);
  endtask

  task automatic model_edge(input logic [3:0] k);
    logic [15:0] chain_n, ld;
    logic [3:0]  press;
    logic        fast, tick, ev0, ev1, ev3, at_max, all_diff;
    int          nxt;
    chain_n = m_we ? m_wv : (m_inc ? bcd_inc(time_v) : time_v);
    raw_hist.push_front(k);
    void'(raw_hist.pop_back());
    fast  = ~m_deb[2];
    press = 4'h0;
    // synced sample seen at this edge is the raw level from two edges earlier
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j < int'(DB) + 2; j++) if (raw_hist[j][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) begin
        if (m_deb[b]) press[b] = 1'b1;
        m_deb[b] = ~m_deb[b];
      end
    end
    tick   = ((phase % TD) == TD - 1) && (fast || (((phase / TD) % FM) == FM - 1));
    ev0    = press[0];
    ev3    = press[3] && !ev0;
    ev1    = press[1] && !ev0 && !ev3;
    at_max = (time_v == 16'h5959);
    nxt    = m_state;
    ld     = m_wv;
    case (m_state)
      0: if (ev0) nxt = 1; else if (ev3) begin nxt = 3; ld = 16'h0; end
         else if (ev1) begin nxt = 3; ld = PRESET; end
      1: if (ev0) nxt = 0; else if (tick && at_max) nxt = 4; else if (ev1) nxt = 2;
      2: if (ev0) nxt = 0; else if (tick && at_max) nxt = 4; else if (ev1) nxt = 1;
      3: nxt = 0;
      default: if (ev3) begin nxt = 3; ld = 16'h0; end
               else if (ev1) begin nxt = 3; ld = PRESET; end
    endcase
    m_inc = tick && (m_state == 1 || m_state == 2) && !at_max && !ev0;
    m_we  = (nxt == 3);
    m_wv  = ld;
    if (nxt == 2 && m_state != 2) m_lap = time_v;
    m_disp = (nxt == 2) ? m_lap : time_v;
    m_run  = (nxt == 1 || nxt == 2);
    phase  = (m_state == 0 && nxt == 1) ? 0 : phase + 1;
    m_state = nxt;
    time_v  = chain_n;
  endtask

  // One clock: drive inputs, advance model, compare every output
  task automatic cycle(input logic [3:0] k, input bit ovr = 1'b0, input logic [15:0] tv = 16'h0000);
    if (ovr) time_v = tv;
    KEY = k;
    TIME_BCD = time_v;
    prev_time = time_v;
    @(posedge CLK);
    model_edge(k);
    #1;
    chk("state",        16'(STATE),        16'(m_state));
    chk("increment",    16'(INCREMENT),    16'(m_inc));
    chk("write_enable", 16'(WRITE_ENABLE), 16'(m_we));
    chk("write_value",  WRITE_VALUE,       m_wv);
    chk("disp_bcd",     DISP_BCD,          m_disp);
    chk("running",      16'(RUNNING),      16'(m_run));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'hF);
  endtask

  initial begin
    int t, t_run, t_inc, t_inc2, gap, t_prev;
    bit saw, saw_we;
    logic [3:0] lvl;

    // Power-on reset
    RESET_N = 1'b0; KEY = 4'hF; time_v = 16'h0; TIME_BCD = 16'h0;
    model_reset();
    #1;
    chk("rst_state", 16'(STATE), 16'd0);
    chk("rst_increment", 16'(INCREMENT), 16'd0);
    chk("rst_write_enable", 16'(WRITE_ENABLE), 16'd0);
    chk("rst_write_value", WRITE_VALUE, 16'h0);
    chk("rst_disp", DISP_BCD, 16'h0);
    chk("rst_running", 16'(RUNNING), 16'd0);
    #21 RESET_N = 1'b1;
    idle(4);

    // Two-cycle glitch on KEY0 is filtered
    cycle(4'hE); cycle(4'hE);
    idle(8);
    chk("glitch_ignored", 16'(STATE), 16'd0);

    // Start, then first count after a full 12-cycle period and every 12 after
    t_run = -1; t_inc = -1; t_inc2 = -1;
    for (int c = 0; c < 50 && t_inc2 < 0; c++) begin
      cycle((c < 6) ? 4'hE : 4'hF);
      if (t_run < 0 && STATE == 3'd1) t_run = c;
      else if (t_run >= 0 && INCREMENT) begin
        if (t_inc < 0) t_inc = c; else t_inc2 = c;
      end
    end
    chk("start_latency", 16'(t_run), 16'd4);
    chk("first_inc_gap", 16'(t_inc - t_run), 16'd12);
    chk("slow_period", 16'(t_inc2 - t_inc), 16'd12);

    // Fast mode while KEY2 held
    t_prev = -1; gap = -1;
    for (int c = 0; c < 40; c++) begin
      cycle(4'hB);
      if (INCREMENT) begin
        if (t_prev >= 0) gap = c - t_prev;
        t_prev = c;
      end
    end
    chk("fast_period", 16'(gap), 16'd4);
    idle(8);

    // Lap freeze at 00:12 while the counter keeps running
    for (int c = 0; c < 6; c++) cycle((c < 4) ? 4'hD : 4'hF, 1'b1, 16'h0012);
    chk("lap_state", 16'(STATE), 16'd2);
    chk("lap_disp", DISP_BCD, 16'h0012);
    for (int c = 0; c < 40 && time_v != 16'h0013; c++) cycle(4'hF);
    cycle(4'hF); cycle(4'hF);
    chk("lap_hold", DISP_BCD, 16'h0012);
    t = -1;
    for (int c = 0; c < 10; c++) begin
      cycle((c < 4) ? 4'hD : 4'hF);
      if (t < 0 && STATE == 3'd1) begin
        t = c;
        chk("lap_exit_disp", DISP_BCD, prev_time);
      end
    end
    chk("lap_exit_cycle", 16'(t), 16'd4);

    // Halt at 59:59
    saw = 1'b0; t = -1;
    for (int c = 0; c < 40 && t < 0; c++) begin
      cycle(4'hF, 1'b1, 16'h5959);
      if (INCREMENT) saw = 1'b1;
      if (STATE == 3'd4) t = c;
    end
    chk("full_reached", 16'(t >= 0), 16'd1);
    chk("full_no_inc", 16'(saw), 16'd0);
    for (int c = 0; c < 12; c++) cycle((c < 4) ? 4'hE : 4'hF);
    chk("full_key0_ignored", 16'(STATE), 16'd4);
    t = -1;
    for (int c = 0; c < 12; c++) begin
      cycle((c < 4) ? 4'h7 : 4'hF);
      if (WRITE_ENABLE) begin
        t = c;
        chk("full_clear_value", WRITE_VALUE, 16'h0000);
        chk("full_clear_state", 16'(STATE), 16'd3);
      end
    end
    chk("full_clear_cycle", 16'(t), 16'd4);
    chk("full_clear_done", 16'(STATE), 16'd0);

    // Preset and clear loads from STOPPED
    t = -1;
    for (int c = 0; c < 12; c++) begin
      cycle((c < 4) ? 4'hD : 4'hF);
      if (WRITE_ENABLE) begin
        t = c;
        chk("preset_value", WRITE_VALUE, 16'h5900);
        chk("preset_state", 16'(STATE), 16'd3);
      end
    end
    chk("preset_cycle", 16'(t), 16'd4);
    chk("preset_done", 16'(STATE), 16'd0);
    t = -1;
    for (int c = 0; c < 12; c++) begin
      cycle((c < 4) ? 4'h7 : 4'hF);
      if (WRITE_ENABLE) begin
        t = c;
        chk("clear_value", WRITE_VALUE, 16'h0000);
      end
    end
    chk("clear_cycle", 16'(t), 16'd4);

    // KEY0 and KEY3 together: start wins, no load
    saw_we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle((c < 4) ? 4'h6 : 4'hF);
      if (WRITE_ENABLE) saw_we = 1'b1;
    end
    chk("both_state", 16'(STATE), 16'd1);
    chk("both_no_load", 16'(saw_we), 16'd0);

    // Asynchronous reset while running
    idle(5);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_state", 16'(STATE), 16'd0);
    chk("midrst_increment", 16'(INCREMENT), 16'd0);
    chk("midrst_disp", DISP_BCD, 16'h0);
    model_reset();
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cycle(4'hF);
      if (INCREMENT) saw = 1'b1;
    end
    chk("midrst_no_inc", 16'(saw), 16'd0);

    // Random key activity with occasional jumps near 59:59
    lvl = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) lvl[b] = ~lvl[b];
      if ($urandom_range(0, 59) == 0) cycle(lvl, 1'b1, ($urandom_range(0, 1) == 1) ? 16'h5959 : 16'h5958);
      else cycle(lvl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Control FSM for the mm:ss BCD counter chain driving the four 7-segment displays. Debounces the four push-buttons and generates the 1 Hz or fast count-increment pulse. Sequences start/stop, lap freeze, clear and preset loads, and auto-halts at 59:59. Sits between KEY and the counter chain's INCREMENT/WRITE_ENABLE/WRITE_VALUE inputs. Supplies the display decoders with DISP_BCD.

Parameters:
TICK_DIV, 5000000, CLK cycles per base tick (10 Hz at 50 MHz)
FAST_MULT, 10, base ticks per normal count (normal = 1 Hz)
DEBOUNCE_CYCLES, 250000, cycles a synchronized key must be stable before its debounced level changes
PRESET_VALUE, 16'h5900, BCD mm:ss loaded by preset command

Ports:
CLK  in  1  system clock (50 MHz)
RESET_N  in  1  asynchronous active-low reset
KEY  in  4  raw push-buttons, active-low (0 = pressed), asynchronous
TIME_BCD  in  16  current counter value {min_hi,min_lo,sec_hi,sec_lo}
INCREMENT  out  1  one-cycle pulse: advance counter chain by one
WRITE_ENABLE  out  1  one-cycle load strobe to counter chain
WRITE_VALUE  out  16  BCD load value, valid while WRITE_ENABLE=1
DISP_BCD  out  16  value to display (live or lap-frozen)
STATE  out  3  FSM state: STOPPED=0, RUNNING=1, LAP=2, LOAD=3, FULL=4
RUNNING  out  1  1 in RUNNING or LAP

Behaviour:
- Reset (async on RESET_N=0): STATE=STOPPED; INCREMENT, WRITE_ENABLE, RUNNING=0; WRITE_VALUE=0; DISP_BCD=0; prescalers=0; debounced levels=1 (released); sync flops=1.
- Key path per key: 2-flop synchronizer. Stability counter resets on any change of the synced level. The debounced level takes the synced value after DEBOUNCE_CYCLES consecutive equal cycles. A press event is a one-cycle pulse on a debounced 1->0 transition. Release produces no event.
- Key roles:
  - KEY0 press: start/stop.
  - KEY1 press: lap toggle when running; preset load when STOPPED/FULL.
  - KEY3 press: clear.
  - KEY2 debounced level 0: fast mode.
- Same-cycle press priority: KEY0 > KEY3 > KEY1. Lower-priority events in that cycle are dropped.
- Prescaler: base counter 0..TICK_DIV-1 produces a base pulse at the terminal count. Slow counter 0..FAST_MULT-1 advances on base pulses. The tick is the base pulse in fast mode, otherwise the base pulse with slow counter at terminal. Both counters are cleared on STOPPED->RUNNING, so the first count is a full period. Counters free-run in other states.
- INCREMENT: registered; asserts the cycle after a tick, only in RUNNING/LAP, and only if TIME_BCD != 16'h5959.
- A tick with TIME_BCD == 16'h5959 gives no INCREMENT, next state FULL.
- Transitions:
  - STOPPED: KEY0 -> RUNNING. KEY3 -> LOAD (value 16'h0000). KEY1 -> LOAD (PRESET_VALUE).
  - RUNNING: KEY0 -> STOPPED. KEY1 -> LAP (capture TIME_BCD into lap register). Tick at 59:59 -> FULL.
  - LAP: counting continues. KEY0 -> STOPPED. KEY1 -> RUNNING. Tick at 59:59 -> FULL. KEY3 ignored.
  - LOAD: exactly one cycle. WRITE_ENABLE=1, WRITE_VALUE=selected value. Always -> STOPPED.
  - FULL: KEY0 ignored. KEY3 -> LOAD 0000. KEY1 -> LOAD PRESET_VALUE.
- RUNNING state ignores KEY3; RUNNING + KEY3 stays RUNNING.
- WRITE_VALUE holds its last load value outside LOAD.
- A tick coinciding with a KEY0 stop in RUNNING/LAP: stop wins, no INCREMENT.
- DISP_BCD: registered copy of TIME_BCD (1-cycle latency) except in LAP, where it holds the captured value. On leaving LAP it resumes tracking on the next cycle.

Test Plan:
- Parameters for all scenarios: TICK_DIV=4, FAST_MULT=3, DEBOUNCE_CYCLES=3.
- Reset mid-RUNNING with RESET_N=0 -> same cycle STATE=0, INCREMENT=0, DISP_BCD=0. After release, no INCREMENT until a KEY0 press.
- KEY0 glitch low for 2 cycles -> no event, STATE stays 0. KEY0 held low 6 cycles -> STATE=1 within 2+3+1 cycles. First INCREMENT exactly 12 cycles after the RUNNING entry, then every 12 cycles. KEY2 held low -> every 4 cycles.
- STOPPED, KEY1 press -> one-cycle WRITE_ENABLE=1 with WRITE_VALUE=16'h5900, STATE 3 then 0. KEY3 press -> WRITE_VALUE=16'h0000.
- RUNNING with TIME_BCD=16'h0012, KEY1 press -> STATE=2, DISP_BCD stays 0012 while TIME_BCD changes to 0013 and INCREMENT keeps pulsing. Second KEY1 -> DISP_BCD tracks 0013 next cycle.
- RUNNING with TIME_BCD=16'h5959 at tick -> no INCREMENT, STATE=4. KEY0 ignored. KEY3 -> LOAD 0000 -> STOPPED.
- KEY0 and KEY3 press events in the same cycle while STOPPED -> STATE=1, no WRITE_ENABLE.
